fft_in_packer: RTL and testbench

FFT_IN_PACKER -- requirements
Module: fft_in_packer

---
 rtl/fft_in_packer_pkg.sv | 19 +
 rtl/fft_in_packer_if.sv | 23 ++
 rtl/fft_in_packer_bank.sv | 32 +++
 rtl/fft_in_packer.sv | 117 +++++++++++
 tb/tb_fft_in_packer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_in_packer_pkg.sv
// Shared FFT definitions: sample width, lane count and the complex sample type
// used by the input packer and the butterfly stages.
package fft_pkg;

    localparam int SAMPLE_W = 13;
    localparam int N_LANE   = 16;
    localparam int LANE_W   = $clog2(N_LANE);

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    // Number of occupied banks in the two-bank ping-pong buffer.
    function automatic logic [1:0] count_full(input logic [1:0] full);
        return {1'b0, full[0]} + {1'b0, full[1]};
    endfunction

endpackage

// File: rtl/fft_in_packer_if.sv
// Sample stream in, packed 16-lane block out, for the FFT input packer.
interface fft_in_packer_if #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int N_LANE   = fft_pkg::N_LANE
);
    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] s_real;
    logic signed [SAMPLE_W-1:0] s_imag;
    logic                       valid_out;
    logic signed [SAMPLE_W-1:0] out_real [0:N_LANE-1];
    logic signed [SAMPLE_W-1:0] out_imag [0:N_LANE-1];

    modport master (
        output s_valid, s_real, s_imag,
        input  s_ready, valid_out, out_real, out_imag
    );

    modport slave (
        input  s_valid, s_real, s_imag,
        output s_ready, valid_out, out_real, out_imag
    );
endinterface

// File: rtl/fft_in_packer_bank.sv
// One 16-entry complex register bank: indexed single write, all entries read in parallel.
module fft_pack_bank #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int N_LANE   = fft_pkg::N_LANE,
    parameter int AW       = $clog2(N_LANE)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic signed [SAMPLE_W-1:0] wr_real,
    input  logic signed [SAMPLE_W-1:0] wr_imag,
    output logic signed [SAMPLE_W-1:0] rd_real [0:N_LANE-1],
    output logic signed [SAMPLE_W-1:0] rd_imag [0:N_LANE-1]
);

    logic signed [SAMPLE_W-1:0] mem_real [0:N_LANE-1];
    logic signed [SAMPLE_W-1:0] mem_imag [0:N_LANE-1];

    // Storage is intentionally left out of reset; the packer's full flags gate its use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_real[waddr] <= wr_real;
            mem_imag[waddr] <= wr_imag;
        end
    end

    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_rd
        assign rd_real[gi] = mem_real[gi];
        assign rd_imag[gi] = mem_imag[gi];
    end

endmodule

// File: rtl/fft_in_packer.sv
// Serial-to-parallel packer: collects 16 complex samples per block into ping-pong
// banks and presents each block to the 16-lane butterfly input as a one-cycle pulse.
module fft_in_packer #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int N_LANE   = fft_pkg::N_LANE
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       hold,
    output logic [fft_pkg::LANE_W-1:0] fill_level,
    output logic [1:0]                 blocks_pending,
    fft_in_packer_if.slave             io
);
    import fft_pkg::*;

    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(N_LANE - 1);

    logic              wr_bank_reg, wr_bank_next;
    logic              rd_bank_reg, rd_bank_next;
    logic [LANE_W-1:0] wr_idx_reg,  wr_idx_next;
    logic [1:0]        full_reg,    full_next;
    logic              valid_out_reg;

    logic accept;
    logic emit;
    logic [1:0] bank_we;

    logic signed [SAMPLE_W-1:0] bank_real    [0:1][0:N_LANE-1];
    logic signed [SAMPLE_W-1:0] bank_imag    [0:1][0:N_LANE-1];
    logic signed [SAMPLE_W-1:0] out_real_reg [0:N_LANE-1];
    logic signed [SAMPLE_W-1:0] out_imag_reg [0:N_LANE-1];

    // Ready looks only at registered occupancy, so a bank freed this edge is usable next cycle.
    assign io.s_ready = !full_reg[wr_bank_reg] && !flush;
    assign accept     = io.s_valid && io.s_ready;
    assign emit       = full_reg[rd_bank_reg] && !hold && !flush;

    always_comb begin
        full_next    = full_reg;
        wr_idx_next  = wr_idx_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        if (accept) begin
            wr_idx_next = wr_idx_reg + LANE_W'(1);
            if (wr_idx_reg == LAST_IDX) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = !wr_bank_reg;
            end
        end
        // Accept and emit always target different banks, so both updates can land together.
        if (emit) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = !rd_bank_reg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            full_reg      <= '0;
            valid_out_reg <= 1'b0;
        end else if (flush) begin
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            full_reg      <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            wr_bank_reg   <= wr_bank_next;
            rd_bank_reg   <= rd_bank_next;
            wr_idx_reg    <= wr_idx_next;
            full_reg      <= full_next;
            valid_out_reg <= emit;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_we[gi] = accept && (wr_bank_reg == gi[0]);

        fft_pack_bank #(
            .SAMPLE_W (SAMPLE_W),
            .N_LANE   (N_LANE)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[gi]),
            .waddr   (wr_idx_reg),
            .wr_real (io.s_real),
            .wr_imag (io.s_imag),
            .rd_real (bank_real[gi]),
            .rd_imag (bank_imag[gi])
        );
    end

    // Output lanes only move on emission; flush leaves the last block visible.
    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                out_real_reg[gi] <= '0;
                out_imag_reg[gi] <= '0;
            end else if (emit) begin
                out_real_reg[gi] <= rd_bank_reg ? bank_real[1][gi] : bank_real[0][gi];
                out_imag_reg[gi] <= rd_bank_reg ? bank_imag[1][gi] : bank_imag[0][gi];
            end
        end

        assign io.out_real[gi] = out_real_reg[gi];
        assign io.out_imag[gi] = out_imag_reg[gi];
    end

    assign io.valid_out     = valid_out_reg;
    assign fill_level       = wr_idx_reg;
    assign blocks_pending   = count_full(full_reg);

endmodule

// File: tb/tb_fft_in_packer.sv
// Scoreboard bench for fft_in_packer: a queue-based model of accepted samples predicts
// every emitted block; a negedge monitor checks each valid_out pulse against it.
module tb_fft_in_packer;

    localparam int SW = 13;
    localparam int NL = 16;

    typedef struct {
        int re [NL];
        int im [NL];
    } blk_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       flush = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] fill_level;
    logic [1:0] blocks_pending;

    fft_in_packer_if #(.SAMPLE_W(SW), .N_LANE(NL)) intf ();

    fft_in_packer #(.SAMPLE_W(SW), .N_LANE(NL)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .hold           (hold),
        .fill_level     (fill_level),
        .blocks_pending (blocks_pending),
        .io             (intf)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   refusals = 0;
    int   last_acc_cyc = 0;
    int   part_re [$];
    int   part_im [$];
    blk_t exp_q [$];
    blk_t last_blk;
    int   pulse_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: every pulse must match the oldest predicted block, lane for lane.
    always @(negedge clk) begin
        if (rstn === 1'b1 && intf.valid_out === 1'b1) begin
            blk_t e;
            int   bad;
            pulse_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_block: valid_out pulse with no block expected (t=%0t)", $time);
            end else begin
                e   = exp_q.pop_front();
                bad = -1;
                for (int k = NL - 1; k >= 0; k--) begin
                    if (intf.out_real[k] !== SW'(e.re[k]) || intf.out_imag[k] !== SW'(e.im[k]))
                        bad = k;
                end
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL block_data: lane %0d got (%0d,%0d) expected (%0d,%0d)", bad,
                             intf.out_real[bad], intf.out_imag[bad], e.re[bad], e.im[bad]);
                end else begin
                    $display("block ok: lane0=(%0d,%0d) lane15=(%0d,%0d) cyc=%0d",
                             e.re[0], e.im[0], e.re[NL-1], e.im[NL-1], cyc);
                end
                last_blk = e;
            end
        end
    end

    // One clock of stimulus; the model is updated from what the DUT accepted at the edge.
    task automatic cycle(input bit v, input int re, input int im, input bit h, input bit f,
                         output bit acc);
        @(negedge clk);
        intf.s_valid = v;
        intf.s_real  = SW'(re);
        intf.s_imag  = SW'(im);
        hold  = h;
        flush = f;
        #3;
        acc = v && (intf.s_ready === 1'b1);
        check("fill_level", int'(fill_level), part_re.size());
        check("blocks_pending", int'(blocks_pending), exp_q.size());
        if (acc) last_acc_cyc = cyc;
        @(posedge clk);
        if (f) begin
            part_re.delete();
            part_im.delete();
            exp_q.delete();
        end else if (acc) begin
            part_re.push_back(re);
            part_im.push_back(im);
            if (part_re.size() == NL) begin
                blk_t b;
                for (int k = 0; k < NL; k++) begin
                    b.re[k] = part_re[k];
                    b.im[k] = part_im[k];
                end
                exp_q.push_back(b);
                part_re.delete();
                part_im.delete();
            end
        end
    endtask

    task automatic push(input int re, input int im, input bit h);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 200) begin
            cycle(1'b1, re, im, h, 1'b0, acc);
            if (!acc) refusals++;
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: sample (%0d,%0d) not accepted in 200 cycles", re, im);
        end
    endtask

    task automatic idle(input int n, input bit h);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, h, 1'b0, acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < NL; k++)
            if (intf.out_real[k] !== '0 || intf.out_imag[k] !== '0) nz++;
        check({tag, "_valid_out"}, int'(intf.valid_out), 0);
        check({tag, "_s_ready"}, int'(intf.s_ready), 1);
        check({tag, "_fill_level"}, int'(fill_level), 0);
        check({tag, "_blocks_pending"}, int'(blocks_pending), 0);
        check({tag, "_nonzero_lanes"}, nz, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        intf.s_valid = 1'b0;
        intf.s_real  = '0;
        intf.s_imag  = '0;
        #2;
        check_reset_outputs("reset");
        #21 rstn = 1'b1;

        // 16 ramp samples: one pulse at the edge after the 16th accept.
        refusals = 0;
        pulse_cyc.delete();
        for (int k = 0; k < NL; k++) push(k, -k, 1'b0);
        idle(3, 1'b0);
        check("t1_pulses", pulse_cyc.size(), 1);
        if (pulse_cyc.size() == 1) check("t1_latency", pulse_cyc[0] - last_acc_cyc, 2);
        check("t1_refusals", refusals, 0);

        // 64 back-to-back: four pulses 16 cycles apart, ready never drops.
        refusals = 0;
        pulse_cyc.delete();
        for (int k = 0; k < 64; k++) push(1000 + 37 * k, -2000 + 11 * k, 1'b0);
        idle(3, 1'b0);
        check("t2_pulses", pulse_cyc.size(), 4);
        check("t2_refusals", refusals, 0);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("t2_spacing", pulse_cyc[i] - pulse_cyc[i-1], 16);

        // Hold with 40 samples offered: both banks fill, then drain back-to-back.
        refusals = 0;
        pulse_cyc.delete();
        for (int k = 0; k < 32; k++) push(3 * k - 50, 7 - k, 1'b1);
        check("t3_refusals_first32", refusals, 0);
        cycle(1'b1, 500, -500, 1'b1, 1'b0, acc);
        check("t3_ready_drop", int'(acc), 0);
        check("t3_fill_level", int'(fill_level), 0);
        check("t3_blocks_pending", int'(blocks_pending), 2);
        check("t3_no_pulse_in_hold", pulse_cyc.size(), 0);
        for (int k = 0; k < 8; k++) push(500 + k, -500 - k, 1'b0);
        idle(2, 1'b0);
        check("t3_pulses", pulse_cyc.size(), 2);
        if (pulse_cyc.size() == 2) check("t3_consecutive", pulse_cyc[1] - pulse_cyc[0], 1);
        check("t3_fill_after", int'(fill_level), 8);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, acc);

        // Full-scale extremes must pass through with signs intact.
        pulse_cyc.delete();
        for (int k = 0; k < NL; k++) push(-4096, 4095, 1'b0);
        idle(3, 1'b0);
        check("t4_pulses", pulse_cyc.size(), 1);
        check("t4_lane7_real", int'(intf.out_real[7]), -4096);
        check("t4_lane7_imag", int'(intf.out_imag[7]), 4095);

        // Partial block discarded by flush, including the sample offered during flush.
        pulse_cyc.delete();
        for (int k = 0; k < 7; k++) push(k + 1, k + 2, 1'b0);
        cycle(1'b1, 999, 999, 1'b0, 1'b1, acc);
        check("t5_flush_drop", int'(acc), 0);
        idle(2, 1'b0);
        check("t5_fill_after_flush", int'(fill_level), 0);
        check("t5_no_pulse", pulse_cyc.size(), 0);
        check("t5_out_retained", int'(intf.out_real[0]), -4096);
        for (int k = 0; k < NL; k++) push(100 + k, -100 - k, 1'b0);
        idle(3, 1'b0);
        check("t5_pulses", pulse_cyc.size(), 1);
        check("t5_lane0", int'(intf.out_real[0]), 100);

        // Asynchronous reset with one full bank and a partial one under hold.
        for (int k = 0; k < 20; k++) push(200 + k, 300 + k, 1'b1);
        idle(1, 1'b1);
        check("t6_pending_before", int'(blocks_pending), 1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("t6_reset");
        part_re.delete();
        part_im.delete();
        exp_q.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        pulse_cyc.delete();
        for (int k = 0; k < NL; k++) push(-7 * k, 9 * k, 1'b0);
        idle(3, 1'b0);
        check("t6_pulses", pulse_cyc.size(), 1);

        // Random traffic with random hold and occasional flush.
        for (int i = 0; i < 600; i++) begin
            bit v, h, f;
            int re, im;
            v  = ($urandom_range(0, 3) != 0);
            h  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 49) == 0);
            re = int'($urandom_range(0, 8191)) - 4096;
            im = int'($urandom_range(0, 8191)) - 4096;
            cycle(v, re, im, h, f, acc);
        end
        idle(10, 1'b0);
        check("rand_drained", exp_q.size(), 0);
        idle(5, 1'b0);
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < NL; k++)
                if (intf.out_real[k] !== SW'(last_blk.re[k]) || intf.out_imag[k] !== SW'(last_blk.im[k]))
                    bad++;
            check("out_hold_last_block", bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
